// File: rtl/btn_defs.sv
// Shared definitions for the push-button conditioner: debounce FSM state encoding.
package btn_defs;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM_ON  = 2'd1,
        ST_HELD    = 2'd2,
        ST_ARM_OFF = 2'd3
    } btn_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM, press/release strobes,
// long-press detection and auto-repeat, all outputs registered.
module btn_channel
    import btn_defs::*;
#(
    parameter int DB_CNT   = 1_000_000,
    parameter int HOLD_CNT = 50_000_000,
    parameter int RPT_CNT  = 10_000_000,
    parameter int CNT_W    = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic button_i,
    output logic db_level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o,
    output logic repeat_o
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CNT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CNT - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CNT - 1);

    logic             sync1_q, sync2_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_phase_q, rpt_phase_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_phase_d = rpt_phase_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    state_d  = ST_ARM_ON;
                    db_cnt_d = '0;
                end
            end
            ST_ARM_ON: begin
                if (!sync2_q) begin
                    state_d = ST_IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = ST_HELD;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    repeat_d    = 1'b1;
                    hold_cnt_d  = '0;
                    rpt_cnt_d   = '0;
                    rpt_phase_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                // hold_cnt parks at HOLD_LAST once the repeat phase starts
                if (!sync2_q) begin
                    state_d  = ST_ARM_OFF;
                    db_cnt_d = '0;
                end else if (!rpt_phase_q) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        long_d      = 1'b1;
                        repeat_d    = 1'b1;
                        rpt_phase_d = 1'b1;
                        rpt_cnt_d   = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                end else if (rpt_cnt_q == RPT_LAST) begin
                    repeat_d  = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
                end
            end
            ST_ARM_OFF: begin
                if (sync2_q) begin
                    state_d = ST_HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = ST_IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= ST_IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            sync1_q     <= button_i;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    assign db_level_o   = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;
    assign repeat_o     = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button front end: one independent btn_channel per raw button input.
module button_conditioner #(
    parameter int N_CH     = 2,
    parameter int DB_CNT   = 1_000_000,
    parameter int HOLD_CNT = 50_000_000,
    parameter int RPT_CNT  = 10_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] button_in,
    output logic [N_CH-1:0] db_level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_p,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] repeat_p
);

    localparam int MAX_DH  = (DB_CNT > HOLD_CNT) ? DB_CNT : HOLD_CNT;
    localparam int MAX_CNT = (MAX_DH > RPT_CNT) ? MAX_DH : RPT_CNT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    if (DB_CNT < 2 || HOLD_CNT < 2 || RPT_CNT < 1 || N_CH < 1) begin : g_bad_params
        $error("button_conditioner: illegal parameters (need DB_CNT>=2, HOLD_CNT>=2, RPT_CNT>=1, N_CH>=1)");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_channel #(
            .DB_CNT   (DB_CNT),
            .HOLD_CNT (HOLD_CNT),
            .RPT_CNT  (RPT_CNT),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .button_i     (button_in[i]),
            .db_level_o   (db_level[i]),
            .press_o      (press[i]),
            .release_o    (release_p[i]),
            .long_press_o (long_press[i]),
            .repeat_o     (repeat_p[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/hold/repeat counts.
module tb_button_conditioner;
    import btn_defs::*;

    localparam int N_CH     = 2;
    localparam int DB_CNT   = 4;
    localparam int HOLD_CNT = 20;
    localparam int RPT_CNT  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] button_in;
    logic [1:0] db_level, press, release_p, long_press, repeat_p;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    button_conditioner #(
        .N_CH     (N_CH),
        .DB_CNT   (DB_CNT),
        .HOLD_CNT (HOLD_CNT),
        .RPT_CNT  (RPT_CNT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .button_in  (button_in),
        .db_level   (db_level),
        .press      (press),
        .release_p  (release_p),
        .long_press (long_press),
        .repeat_p   (repeat_p)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] lvl, input logic [1:0] pr,
                              input logic [1:0] rl, input logic [1:0] lp, input logic [1:0] rp);
        check({tag, ".db_level"},   32'(db_level),   32'(lvl));
        check({tag, ".press"},      32'(press),      32'(pr));
        check({tag, ".release_p"},  32'(release_p),  32'(rl));
        check({tag, ".long_press"}, 32'(long_press), 32'(lp));
        check({tag, ".repeat_p"},   32'(repeat_p),   32'(rp));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".state0"}, 32'(dut.g_ch[0].u_ch.state_q), 32'(ST_IDLE));
        check({tag, ".state1"}, 32'(dut.g_ch[1].u_ch.state_q), 32'(ST_IDLE));
    endtask

    initial begin
        int off;
        logic [1:0] rp;

        // reset held with buttons pressed: nothing may come out
        reset     = 1'b1;
        button_in = 2'b11;
        for (int c = 1; c <= 3; c++) begin
            step();
            expect_out($sformatf("rst@%0d", c), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        end
        expect_idle("rst");
        reset     = 1'b0;
        button_in = 2'b00;
        step();
        expect_out("post_rst", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        expect_idle("post_rst");

        // ch0 press, long hold with repeats
        exp_q = '{8'd0, 8'd20, 8'd28, 8'd36, 8'd44, 8'd52};
        button_in = 2'b01;
        for (int c = 1; c <= 63; c++) begin
            step();
            off = c - 7;
            rp  = 2'b00;
            if (c >= 7 && exp_q.size() > 0 && int'(exp_q[0]) == off) begin
                rp = 2'b01;
                void'(exp_q.pop_front());
            end
            expect_out($sformatf("hold@%0d", c), (c >= 7) ? 2'b01 : 2'b00,
                       (off == 0) ? 2'b01 : 2'b00, 2'b00,
                       (off == 20) ? 2'b01 : 2'b00, rp);
        end

        // ch0 release after the long hold
        button_in = 2'b00;
        for (int c = 1; c <= 12; c++) begin
            step();
            expect_out($sformatf("rel@%0d", c), (c < 7) ? 2'b01 : 2'b00, 2'b00,
                       (c == 7) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        end
        expect_idle("rel");

        // 3-cycle glitch is rejected
        button_in = 2'b01;
        for (int c = 1; c <= 13; c++) begin
            if (c == 4) button_in = 2'b00;
            step();
            expect_out($sformatf("glitch@%0d", c), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        end
        expect_idle("glitch");

        // press again, then a 1-cycle low dip while held
        button_in = 2'b01;
        for (int c = 1; c <= 10; c++) begin
            step();
            expect_out($sformatf("press2@%0d", c), (c >= 7) ? 2'b01 : 2'b00,
                       (c == 7) ? 2'b01 : 2'b00, 2'b00, 2'b00, (c == 7) ? 2'b01 : 2'b00);
        end
        button_in = 2'b00;
        for (int c = 0; c <= 12; c++) begin
            if (c == 1) button_in = 2'b01;
            step();
            expect_out($sformatf("dip@%0d", c), 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        end
        check("dip.state0", 32'(dut.g_ch[0].u_ch.state_q), 32'(ST_HELD));
        button_in = 2'b00;
        for (int c = 1; c <= 10; c++) begin
            step();
            expect_out($sformatf("rel2@%0d", c), (c < 7) ? 2'b01 : 2'b00, 2'b00,
                       (c == 7) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        end

        // both channels pressed together, then reset while held
        button_in = 2'b11;
        for (int c = 1; c <= 12; c++) begin
            step();
            expect_out($sformatf("both@%0d", c), (c >= 7) ? 2'b11 : 2'b00,
                       (c == 7) ? 2'b11 : 2'b00, 2'b00, 2'b00, (c == 7) ? 2'b11 : 2'b00);
        end
        reset = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            step();
            expect_out($sformatf("midrst@%0d", c), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        end
        reset     = 1'b0;
        button_in = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            step();
            expect_out($sformatf("after@%0d", c), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        end
        expect_idle("after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
